io_ctrl: RTL and testbench

IO_CTRL -- requirements
Module: io_ctrl

---
 rtl/io_pkg.sv | 20 ++
 rtl/io_debounce.sv | 49 ++++
 rtl/io_ctrl.sv | 127 ++++++++++++
 tb/tb_io_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// io_ctrl shared definitions.
// Register byte offsets and bus FSM state type.
package io_pkg;

    localparam logic [4:0] IO_SW   = 5'h00;
    localparam logic [4:0] IO_KEY  = 5'h04;
    localparam logic [4:0] IO_EDGE = 5'h08;
    localparam logic [4:0] IO_LEDR = 5'h0C;
    localparam logic [4:0] IO_HEX  = 5'h10;

    localparam int N_SW  = 10;
    localparam int N_KEY = 4;
    localparam int N_IN  = N_SW + N_KEY;

    typedef enum logic {
        BUS_IDLE = 1'b0,
        BUS_ACK  = 1'b1
    } bus_state_e;

endpackage

// File: rtl/io_debounce.sv
// One-bit 2-flop synchronizer plus stability-counter debouncer.
// rise_o pulses in the cycle the debounced value is about to go 0->1.
module io_debounce #(
    parameter int DEB_CYCLES = 4,
    parameter bit INVERT     = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic deb_o,
    output logic rise_o
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          deb_q;
    logic [CW-1:0] cnt_q;
    logic          s;
    logic          done;

    assign s      = sync2_q ^ INVERT;
    assign done   = (s != deb_q) && (cnt_q == CW'(DEB_CYCLES - 1));
    assign deb_o  = deb_q;
    assign rise_o = done & s;

    // Synchronize, then count consecutive differing cycles before flipping.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            if (s == deb_q) begin
                cnt_q <= '0;
            end else if (done) begin
                deb_q <= s;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/io_ctrl.sv
// Memory-mapped switch/key/LED/7-seg controller.
// Two-state bus FSM, debounced inputs with sticky W1C edge flags.
module io_ctrl
    import io_pkg::*;
#(
    parameter int         DEB_CYCLES = 4,
    parameter logic [9:0] LED_RST    = 10'h000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        ack,
    input  logic [9:0]  sw_in,
    input  logic [3:0]  key_in,
    output logic [9:0]  ledr,
    output logic [23:0] hex_val
);

    logic [N_IN-1:0] raw;
    logic [N_IN-1:0] deb;
    logic [N_IN-1:0] rise;

    bus_state_e      state_q;
    logic            ack_q;
    logic [31:0]     rd_q;
    logic [9:0]      ledr_q;
    logic [23:0]     hex_q;
    logic [N_IN-1:0] edge_q;

    logic            acc;
    logic            wr;
    logic [2:0]      word;
    logic [31:0]     rdata;
    logic [N_IN-1:0] clr;
    logic            unused_bits;

    assign raw         = {key_in, sw_in};
    assign unused_bits = &{1'b0, addr[1:0], wd[31:24]};

    // Keys are active-low; invert them after synchronization.
    for (genvar i = 0; i < N_IN; i++) begin : g_deb
        io_debounce #(
            .DEB_CYCLES(DEB_CYCLES),
            .INVERT    (i >= N_SW)
        ) u_deb (
            .clk   (clk),
            .reset (reset),
            .raw_i (raw[i]),
            .deb_o (deb[i]),
            .rise_o(rise[i])
        );
    end

    assign acc  = (state_q == BUS_IDLE) && req;
    assign wr   = acc && we;
    assign word = addr[4:2];
    assign clr  = (wr && word == IO_EDGE[4:2]) ? wd[N_IN-1:0] : '0;

    // Read mux over the register map; holes and unused bits read 0.
    always_comb begin
        rdata = '0;
        if (word == IO_SW[4:2]) begin
            rdata[N_SW-1:0] = deb[N_SW-1:0];
        end else if (word == IO_KEY[4:2]) begin
            rdata[N_KEY-1:0] = deb[N_IN-1:N_SW];
        end else if (word == IO_EDGE[4:2]) begin
            rdata[N_IN-1:0] = edge_q;
        end else if (word == IO_LEDR[4:2]) begin
            rdata[9:0] = ledr_q;
        end else if (word == IO_HEX[4:2]) begin
            rdata[23:0] = hex_q;
        end
    end

    // Bus FSM: accept in IDLE, pulse ack with captured read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BUS_IDLE;
            ack_q   <= 1'b0;
            rd_q    <= '0;
        end else begin
            case (state_q)
                BUS_IDLE: begin
                    ack_q <= 1'b0;
                    rd_q  <= '0;
                    if (req) begin
                        state_q <= BUS_ACK;
                        ack_q   <= 1'b1;
                        rd_q    <= we ? '0 : rdata;
                    end
                end
                default: begin
                    state_q <= BUS_IDLE;
                    ack_q   <= 1'b0;
                    rd_q    <= '0;
                end
            endcase
        end
    end

    // Register writes; a new edge beats a same-cycle W1C clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            ledr_q <= LED_RST;
            hex_q  <= '0;
            edge_q <= '0;
        end else begin
            if (wr && word == IO_LEDR[4:2]) begin
                ledr_q <= wd[9:0];
            end
            if (wr && word == IO_HEX[4:2]) begin
                hex_q <= wd[23:0];
            end
            edge_q <= (edge_q & ~clr) | rise;
        end
    end

    assign rd      = rd_q;
    assign ack     = ack_q;
    assign ledr    = ledr_q;
    assign hex_val = hex_q;

endmodule

// File: tb/tb_io_ctrl.sv
// Directed and randomized bench for io_ctrl.
// Reference model tracks input history and register effects per cycle.
module tb_io_ctrl;

    localparam int DEB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        ack;
    logic [9:0]  sw_in;
    logic [3:0]  key_in;
    logic [9:0]  ledr;
    logic [23:0] hex_val;

    int n_cmp = 0;
    int n_bad = 0;

    io_ctrl #(
        .DEB_CYCLES(DEB),
        .LED_RST   (10'h000)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .we     (we),
        .addr   (addr),
        .wd     (wd),
        .rd     (rd),
        .ack    (ack),
        .sw_in  (sw_in),
        .key_in (key_in),
        .ledr   (ledr),
        .hex_val(hex_val)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [13:0] s1, s2;
    logic [13:0] hist [DEB];
    int          nh;
    logic [13:0] m_deb;
    logic [13:0] m_edge;
    logic        m_busy;
    logic [9:0]  m_ledr;
    logic [23:0] m_hex;
    logic [31:0] m_rd;

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a[4:2])
            3'd0:    return {22'h0, m_deb[9:0]};
            3'd1:    return {28'h0, m_deb[13:10]};
            3'd2:    return {18'h0, m_edge};
            3'd3:    return {22'h0, m_ledr};
            3'd4:    return {8'h0, m_hex};
            default: return 32'h0;
        endcase
    endfunction

    // Debounced value flips once the last DEB synchronized samples
    // all disagree with it; sync output is the raw input two edges late.
    function automatic void model_step();
        logic [13:0] v, rise, clr;
        logic        all_diff;
        if (reset) begin
            s1 = '0; s2 = '0; nh = 0;
            m_deb = '0; m_edge = '0; m_busy = 1'b0;
            m_ledr = 10'h000; m_hex = '0; m_rd = '0;
            return;
        end
        v   = s2 ^ 14'h3C00;
        clr = '0;
        if (!m_busy && req) begin
            m_busy = 1'b1;
            if (!we) m_rd = m_read(addr);
            else begin
                case (addr[4:2])
                    3'd2: clr = wd[13:0];
                    3'd3: m_ledr = wd[9:0];
                    3'd4: m_hex = wd[23:0];
                    default: ;
                endcase
            end
        end else begin
            m_busy = 1'b0;
        end
        for (int k = DEB - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = v;
        if (nh < DEB) nh++;
        rise = '0;
        for (int b = 0; b < 14; b++) begin
            if (nh >= DEB) begin
                all_diff = 1'b1;
                for (int k = 0; k < DEB; k++)
                    if (hist[k][b] == m_deb[b]) all_diff = 1'b0;
                if (all_diff) begin
                    m_deb[b] = v[b];
                    rise[b]  = v[b];
                end
            end
        end
        m_edge = (m_edge & ~clr) | rise;
        s2 = s1;
        s1 = {key_in, sw_in};
    endfunction

    always @(posedge clk) model_step();

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge one cycle after ack.
    task automatic bus(input logic w, input logic [4:0] a,
                       input logic [31:0] d, input string tag,
                       output logic [31:0] rdata);
        int lat;
        req = 1'b1; we = w; addr = a; wd = d;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ack && lat < 8);
        chk({tag, "_lat"}, 32'(lat), 32'd1);
        rdata = rd;
        if (!w) chk({tag, "_rd"}, rd, m_rd);
        req = 1'b0; we = 1'b0;
        @(negedge clk);
        chk({tag, "_ack_off"}, {31'h0, ack}, 32'h0);
        chk({tag, "_rd_off"}, rd, 32'h0);
    endtask

    logic [31:0] r;

    initial begin
        reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wd = '0;
        sw_in = '0; key_in = 4'hF;
        repeat (5) @(negedge clk);
        chk("rst_ack", {31'h0, ack}, 32'h0);
        chk("rst_rd", rd, 32'h0);
        chk("rst_ledr", {22'h0, ledr}, 32'h0);
        chk("rst_hex", {8'h0, hex_val}, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        bus(1'b0, 5'h0C, 32'h0, "rd_ledr0", r);
        chk("ledr0_val", r, 32'h0);
        bus(1'b0, 5'h00, 32'h0, "rd_sw0", r);
        chk("sw0_val", r, 32'h0);

        // Switch 1 rises: not visible before sync+debounce delay
        sw_in[1] = 1'b1;
        repeat (3) @(negedge clk);
        bus(1'b0, 5'h00, 32'h0, "sw_early", r);
        chk("sw_early_val", r, 32'h0);
        repeat (10) @(negedge clk);
        bus(1'b0, 5'h00, 32'h0, "sw_set", r);
        chk("sw_set_val", r, 32'h2);
        bus(1'b0, 5'h08, 32'h0, "edge_sw", r);
        chk("edge_sw_val", r, 32'h2);
        bus(1'b1, 5'h08, 32'h2, "edge_clr", r);
        bus(1'b0, 5'h08, 32'h0, "edge_clr_rd", r);
        chk("edge_clr_val", r, 32'h0);

        // Glitch shorter than the debounce window
        sw_in[1] = 1'b0;
        repeat (10) @(negedge clk);
        sw_in[1] = 1'b1;
        repeat (3) @(negedge clk);
        sw_in[1] = 1'b0;
        repeat (10) @(negedge clk);
        bus(1'b0, 5'h00, 32'h0, "glitch_sw", r);
        chk("glitch_sw_val", r, 32'h0);
        bus(1'b0, 5'h08, 32'h0, "glitch_edge", r);
        chk("glitch_edge_val", r, 32'h0);

        // Key 0 press, then set-vs-clear race
        key_in = 4'b1110;
        repeat (10) @(negedge clk);
        bus(1'b0, 5'h04, 32'h0, "key_rd", r);
        chk("key_val", r, 32'h1);
        bus(1'b0, 5'h08, 32'h0, "key_edge", r);
        chk("key_edge_val", r, 32'h400);
        bus(1'b1, 5'h08, 32'h400, "key_clr", r);
        key_in = 4'b1111;
        repeat (10) @(negedge clk);
        bus(1'b0, 5'h08, 32'h0, "key_rel_edge", r);
        chk("key_rel_edge_val", r, 32'h0);
        key_in = 4'b1110;
        repeat (5) @(negedge clk);
        bus(1'b1, 5'h08, 32'h400, "race_clr", r);
        bus(1'b0, 5'h08, 32'h0, "race_edge", r);
        chk("race_edge_val", r, 32'h400);

        // Back-to-back LEDR writes with req held
        req = 1'b1; we = 1'b1; addr = 5'h0C; wd = 32'h1;
        @(negedge clk);
        chk("b2b_ack1", {31'h0, ack}, 32'h1);
        chk("b2b_ledr1", {22'h0, ledr}, 32'h1);
        wd = 32'h2;
        @(negedge clk);
        chk("b2b_gap", {31'h0, ack}, 32'h0);
        chk("b2b_hold", {22'h0, ledr}, 32'h1);
        @(negedge clk);
        chk("b2b_ack2", {31'h0, ack}, 32'h1);
        chk("b2b_ledr2", {22'h0, ledr}, 32'h2);
        req = 1'b0; we = 1'b0;
        @(negedge clk);
        bus(1'b1, 5'h10, 32'h00123456, "hex_wr", r);
        chk("hex_val", {8'h0, hex_val}, 32'h123456);
        bus(1'b0, 5'h10, 32'h0, "hex_rd", r);
        chk("hex_rd_val", r, 32'h123456);

        // Reset lands on the accepting edge of a write
        req = 1'b1; we = 1'b1; addr = 5'h0C; wd = 32'h3FF;
        reset = 1'b1;
        @(negedge clk);
        chk("abort_ack", {31'h0, ack}, 32'h0);
        chk("abort_ledr", {22'h0, ledr}, 32'h0);
        req = 1'b0; we = 1'b0; reset = 1'b0;
        @(negedge clk);
        chk("abort_ack2", {31'h0, ack}, 32'h0);
        chk("abort_ledr2", {22'h0, ledr}, 32'h0);

        // Randomized inputs and accesses against the model
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(2, 0) == 0) sw_in = 10'($urandom);
            if ($urandom_range(3, 0) == 0) key_in = 4'($urandom);
            repeat ($urandom_range(8, 0)) @(negedge clk);
            bus(1'($urandom), 5'($urandom_range(7, 0) << 2),
                $urandom, "rnd", r);
            chk("rnd_ledr", {22'h0, ledr}, {22'h0, m_ledr});
            chk("rnd_hex", {8'h0, hex_val}, {8'h0, m_hex});
        end
        repeat (12) @(negedge clk);
        bus(1'b0, 5'h00, 32'h0, "fin_sw", r);
        bus(1'b0, 5'h04, 32'h0, "fin_key", r);
        bus(1'b0, 5'h08, 32'h0, "fin_edge", r);
        bus(1'b0, 5'h1C, 32'h0, "fin_hole", r);
        chk("fin_hole_val", r, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
